// File: rtl/plic_gw_pkg.sv
// Shared types for the PLIC interrupt gateway: per-source state encoding
// and the state every source returns to on reset.
package plic_gw_pkg;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_t;

    localparam gw_state_t GW_RESET_STATE = GW_IDLE;

endpackage

// File: rtl/plic_gateway_cell.sv
// One gateway source: 2-flop synchroniser, edge-history flop, request FSM
// and the retained-edge store for edge-triggered sources.
// Build option: PLIC_GW_EDGE_COUNT_EN turns the single retained-edge flag
// into a saturating CNT_W-bit counter that also counts edges seen while
// the request is still pending.
import plic_gw_pkg::*;

module plic_gateway_cell #(
    parameter bit IS_EDGE = 1'b0,
    parameter int CNT_W   = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic irq_raw,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic req,
    output logic in_service
);

`ifdef PLIC_GW_EDGE_COUNT_EN
    localparam bit USE_CNT = 1'b1;
`else
    localparam bit USE_CNT = 1'b0;
`endif
    // A flag is just a one-bit store that saturates at 1.
    localparam int RET_W = USE_CNT ? CNT_W : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic             hist_q;
    logic             evt;
    logic             edge_evt;
    logic             cmpl;
    gw_state_t        state_q;
    gw_state_t        state_d;
    logic [RET_W-1:0] ret_q;
    logic [RET_W-1:0] ret_d;
    logic             req_q;
    logic             insvc_q;

    assign evt      = IS_EDGE ? (sync_q2 & ~hist_q) : sync_q2;
    assign edge_evt = IS_EDGE & evt;
    assign cmpl     = complete_hit && (state_q == GW_IN_SERVICE);

    // Next-state and retained-edge bookkeeping.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            GW_IDLE: begin
                if (evt) state_d = GW_PENDING;
            end
            GW_PENDING: begin
                if (claim_hit) state_d = GW_IN_SERVICE;
            end
            GW_IN_SERVICE: begin
                // An edge arriving with the complete counts as retained.
                if (complete_hit) begin
                    if ((ret_q != '0) || edge_evt) state_d = GW_PENDING;
                    else                           state_d = GW_IDLE;
                end
            end
            default: state_d = GW_IDLE;
        endcase

        if (cmpl) begin
            // Flag: always consumed. Counter: an edge in the same cycle
            // cancels the decrement (or is consumed directly when empty).
            if (!USE_CNT)                          ret_d = '0;
            else if ((ret_q != '0) && !edge_evt)   ret_d = ret_q - 1'b1;
        end else if (edge_evt && !(&ret_q) &&
                     ((state_q == GW_IN_SERVICE) ||
                      (USE_CNT && (state_q == GW_PENDING)))) begin
            ret_d = ret_q + 1'b1;
        end
    end

    // Synchroniser and edge-history pipeline for the raw line.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync_q1 <= irq_raw;
            sync_q2 <= sync_q1;
            hist_q  <= sync_q2;
        end
    end

    // State, retained edges and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= GW_RESET_STATE;
            ret_q   <= '0;
            req_q   <= 1'b0;
            insvc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            req_q   <= (state_d == GW_PENDING);
            insvc_q <= (state_d == GW_IN_SERVICE);
        end
    end

    assign req        = req_q;
    assign in_service = insvc_q;

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway top: decodes claim/complete IDs into one-hot
// strobes and instantiates one gateway cell per source.
// Build option: PLIC_GW_EDGE_COUNT_EN (see plic_gateway_cell).
import plic_gw_pkg::*;

module plic_gateway #(
    parameter int                      N_interrupts = 32,
    parameter int                      ID_W         = (N_interrupts > 1) ? $clog2(N_interrupts) : 1,
    parameter logic [N_interrupts-1:0] EDGE_SRC     = '0,
    parameter int                      CNT_W        = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [N_interrupts-1:0] irq_in,
    input  logic                    claim_valid,
    input  logic [ID_W-1:0]         claim_id,
    input  logic                    complete_valid,
    input  logic [ID_W-1:0]         complete_id,
    output logic [N_interrupts-1:0] hw_interrupt_requests,
    output logic [N_interrupts-1:0] in_service
);

    logic                    claim_ok;
    logic                    complete_ok;
    logic [N_interrupts-1:0] claim_hot;
    logic [N_interrupts-1:0] complete_hot;

    // IDs that do not name an existing source are dropped here.
    assign claim_ok    = claim_valid    && ({1'b0, claim_id}    < (ID_W+1)'(N_interrupts));
    assign complete_ok = complete_valid && ({1'b0, complete_id} < (ID_W+1)'(N_interrupts));

    // One-hot decode of the claim and complete IDs.
    always_comb begin
        claim_hot    = '0;
        complete_hot = '0;
        for (int i = 0; i < N_interrupts; i++) begin
            if (claim_ok    && (claim_id    == ID_W'(i))) claim_hot[i]    = 1'b1;
            if (complete_ok && (complete_id == ID_W'(i))) complete_hot[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < N_interrupts; g++) begin : g_cell
        plic_gateway_cell #(
            .IS_EDGE (EDGE_SRC[g]),
            .CNT_W   (CNT_W)
        ) u_cell (
            .CLK          (CLK),
            .nRST         (nRST),
            .irq_raw      (irq_in[g]),
            .claim_hit    (claim_hot[g]),
            .complete_hit (complete_hot[g]),
            .req          (hw_interrupt_requests[g]),
            .in_service   (in_service[g])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a request-level
// reference model of the gateway rules.
module tb_plic_gateway;

    localparam int N    = 32;
    localparam int IDW  = 6;
    localparam int CNTW = 2;
    localparam logic [N-1:0] EDGE_MASK = 32'h0000_1222;  // sources 1, 5, 9, 12
`ifdef PLIC_GW_EDGE_COUNT_EN
    localparam bit CNT_MODE = 1'b1;
`else
    localparam bit CNT_MODE = 1'b0;
`endif
    localparam int RMAX = CNT_MODE ? ((1 << CNTW) - 1) : 1;

    logic           CLK = 1'b0;
    logic           nRST;
    logic [N-1:0]   irq_in;
    logic           claim_valid;
    logic [IDW-1:0] claim_id;
    logic           complete_valid;
    logic [IDW-1:0] complete_id;
    logic [N-1:0]   hw_interrupt_requests;
    logic [N-1:0]   in_service;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per source "request outstanding", "being serviced",
    // and number of edges owed after the current service ends.
    bit           m_req [N];
    bit           m_svc [N];
    int           m_ret [N];
    logic [N-1:0] irq_log [$];
    logic [N-1:0] edge_mask;

    plic_gateway #(
        .N_interrupts (N),
        .ID_W         (IDW),
        .EDGE_SRC     (EDGE_MASK),
        .CNT_W        (CNTW)
    ) dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .irq_in                (irq_in),
        .claim_valid           (claim_valid),
        .claim_id              (claim_id),
        .complete_valid        (complete_valid),
        .complete_id           (complete_id),
        .hw_interrupt_requests (hw_interrupt_requests),
        .in_service            (in_service)
    );

    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b0;
            m_svc[i] = 1'b0;
            m_ret[i] = 0;
        end
        irq_log.delete();
        repeat (3) irq_log.push_back('0);
    endtask

    // One clock edge of the gateway rules for source i; s is the line as
    // seen after synchronisation, p the same one cycle earlier.
    task automatic model_step(input int i, input logic s, input logic p);
        bit ev, edg, cl, cp;
        edg = edge_mask[i];
        ev  = edg ? (s && !p) : s;
        cl  = claim_valid    && (int'(claim_id)    == i);
        cp  = complete_valid && (int'(complete_id) == i);
        if (m_req[i]) begin
            if (edg && ev && CNT_MODE && m_ret[i] < RMAX) m_ret[i]++;
            if (cl) begin
                m_req[i] = 1'b0;
                m_svc[i] = 1'b1;
            end
        end else if (m_svc[i]) begin
            if (cp) begin
                m_svc[i] = 1'b0;
                if (edg && ev) begin
                    m_req[i] = 1'b1;
                end else if (m_ret[i] > 0) begin
                    m_req[i] = 1'b1;
                    m_ret[i]--;
                end
                if (!CNT_MODE) m_ret[i] = 0;
            end else if (edg && ev && m_ret[i] < RMAX) begin
                m_ret[i]++;
            end
        end else if (ev) begin
            m_req[i] = 1'b1;
        end
    endtask

    // Advance one clock, update the model, compare both output buses.
    task automatic tick();
        logic [N-1:0] s, p, ereq, esvc;
        s = irq_log[irq_log.size()-2];
        p = irq_log[irq_log.size()-3];
        if (nRST) begin
            for (int i = 0; i < N; i++) model_step(i, s[i], p[i]);
            irq_log.push_back(irq_in);
            if (irq_log.size() > 4) void'(irq_log.pop_front());
        end
        @(posedge CLK);
        #1;
        if (!nRST) model_reset();
        for (int i = 0; i < N; i++) begin
            ereq[i] = m_req[i];
            esvc[i] = m_svc[i];
        end
        check_vec("model_req", hw_interrupt_requests, ereq);
        check_vec("model_svc", in_service, esvc);
    endtask

    task automatic do_claim(input int id);
        claim_valid = 1'b1;
        claim_id    = IDW'(id);
        tick();
        claim_valid = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete_valid = 1'b1;
        complete_id    = IDW'(id);
        tick();
        complete_valid = 1'b0;
    endtask

    function automatic logic [IDW-1:0] pick(input bit want_svc);
        int start, j;
        if ($urandom_range(0, 3) == 0) return IDW'($urandom_range(0, 63));
        start = $urandom_range(0, N-1);
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (want_svc ? m_svc[j] : m_req[j]) return IDW'(j);
        end
        return IDW'(start);
    endfunction

    initial begin
        int episodes;
        edge_mask      = EDGE_MASK;
        nRST           = 1'b0;
        irq_in         = '0;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        model_reset();

        // Reset state
        tick();
        tick();
        check_vec("rst_req", hw_interrupt_requests, '0);
        check_vec("rst_svc", in_service, '0);
        #3 nRST = 1'b1;

        // Level source 3: request, claim, complete with line still high
        irq_in[3] = 1'b1;
        repeat (3) tick();
        check_bit("t1_req_after3", hw_interrupt_requests[3], 1'b1);
        do_claim(3);
        check_bit("t1_req_claimed", hw_interrupt_requests[3], 1'b0);
        check_bit("t1_svc_claimed", in_service[3], 1'b1);
        do_complete(3);
        check_bit("t1_req_cmpl0", hw_interrupt_requests[3], 1'b0);
        tick();
        check_bit("t1_req_rearm", hw_interrupt_requests[3], 1'b1);
        irq_in[3] = 1'b0;
        do_claim(3);
        do_complete(3);
        repeat (3) tick();

        // Edge source 5: pulse, claim, second pulse in service, complete
        irq_in[5] = 1'b1;
        tick();
        irq_in[5] = 1'b0;
        repeat (2) tick();
        check_bit("t2_req", hw_interrupt_requests[5], 1'b1);
        do_claim(5);
        irq_in[5] = 1'b1;
        tick();
        irq_in[5] = 1'b0;
        repeat (2) tick();
        do_complete(5);
        check_bit("t2_req_retained", hw_interrupt_requests[5], 1'b1);
        check_bit("t2_svc_done", in_service[5], 1'b0);
        do_claim(5);
        do_complete(5);

        // Simultaneous claim 2 / complete 7, then an out-of-range claim
        irq_in[2] = 1'b1;
        irq_in[7] = 1'b1;
        repeat (3) tick();
        irq_in[2] = 1'b0;
        irq_in[7] = 1'b0;
        do_claim(7);
        repeat (2) tick();
        claim_valid    = 1'b1;
        claim_id       = IDW'(2);
        complete_valid = 1'b1;
        complete_id    = IDW'(7);
        tick();
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        check_bit("t3_svc2", in_service[2], 1'b1);
        check_bit("t3_svc7", in_service[7], 1'b0);
        check_bit("t3_req7", hw_interrupt_requests[7], 1'b0);
        irq_in[8] = 1'b1;
        repeat (3) tick();
        irq_in[8] = 1'b0;
        do_claim(40);
        check_bit("t3_oor_req8", hw_interrupt_requests[8], 1'b1);
        check_bit("t3_oor_svc8", in_service[8], 1'b0);
        do_claim(8);
        do_complete(8);
        do_complete(2);

        // Five pulses on edge source 1 while pending, then service loop
        for (int k = 0; k < 5; k++) begin
            irq_in[1] = 1'b1;
            tick();
            irq_in[1] = 1'b0;
            tick();
        end
        episodes = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (hw_interrupt_requests[1]) begin
                episodes++;
                do_claim(1);
                do_complete(1);
            end
        end
        vectors++;
        assert (episodes == (CNT_MODE ? 4 : 1)) else begin
            miscompares++;
            $error("FAIL t4_episodes: observed %0d expected %0d", episodes, CNT_MODE ? 4 : 1);
        end

        // Asynchronous reset while sources 0 and 4 are in service
        irq_in[0] = 1'b1;
        irq_in[4] = 1'b1;
        repeat (3) tick();
        do_claim(0);
        do_claim(4);
        check_bit("t5_svc0", in_service[0], 1'b1);
        check_bit("t5_svc4", in_service[4], 1'b1);
        #2 nRST = 1'b0;
        #1;
        check_vec("t5_async_req", hw_interrupt_requests, '0);
        check_vec("t5_async_svc", in_service, '0);
        model_reset();
        repeat (2) tick();
        #3 nRST = 1'b1;
        repeat (2) tick();
        check_bit("t5_req0_early", hw_interrupt_requests[0], 1'b0);
        tick();
        check_bit("t5_req0_rearm", hw_interrupt_requests[0], 1'b1);
        irq_in = '0;
        do_claim(0);
        do_claim(4);
        do_complete(0);
        do_complete(4);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            irq_in         = irq_in ^ ($urandom & $urandom & $urandom);
            claim_valid    = ($urandom_range(0, 1) == 1);
            claim_id       = pick(1'b0);
            complete_valid = ($urandom_range(0, 1) == 1);
            complete_id    = pick(1'b1);
            tick();
        end
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
